// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an incoming PWM line and
// converts them to a duty code floor(high * 2^DUTY_LEN / period) with a
// small restoring divider. Also flags a stuck line and dropped measurements.
module pwm_capture #(
  parameter int unsigned CNT_LEN  = 16,
  parameter int unsigned DUTY_LEN = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm_in_i,
  output logic [DUTY_LEN-1:0] duty_o,
  output logic                duty_valid_o,
  output logic [CNT_LEN-1:0]  period_o,
  output logic [CNT_LEN-1:0]  high_time_o,
  output logic                busy_o,
  output logic                stuck_o,
  output logic                overrun_o,
  output logic                level_o
);

  localparam logic [CNT_LEN-1:0] CntMax = '1;
  localparam int unsigned        ItW    = (DUTY_LEN > 1) ? $clog2(DUTY_LEN) : 1;
  localparam logic [ItW-1:0]     ItLast = ItW'(DUTY_LEN - 1);

  typedef enum logic [1:0] {StIdle, StIter, StDone} div_state_e;

  div_state_e          state_q;
  logic                sync1_q, sync2_q, prev_q;
  logic [CNT_LEN-1:0]  cnt_q, hi_lat_q, div_per_q, div_hi_q;
  logic                armed_q, stuck_q, overrun_q, pend_q, busy_q, dv_q;
  logic [ItW-1:0]      it_q;
  logic [CNT_LEN:0]    rem_q;
  logic [DUTY_LEN-1:0] quo_q, duty_q;
  logic [CNT_LEN-1:0]  period_q, high_q;

  logic                rise, fall, stuck_evt, stuck_req, emit_ok, start;
  logic [CNT_LEN:0]    rem_sh, rem_nx;
  logic                q_bit;
  logic [DUTY_LEN-1:0] quo_nx;

  // Edge detect, stuck detection and one restoring-divider step.
  always_comb begin
    rise      = sync2_q & ~prev_q;
    fall      = ~sync2_q & prev_q;
    stuck_evt = (cnt_q == CntMax) & ~stuck_q & ~rise;
    stuck_req = stuck_evt | pend_q;
    // Stuck strobe may only go out when it cannot collide with a divider strobe.
    emit_ok   = (state_q == StIdle) || (state_q == StDone);
    start     = rise & armed_q & ~busy_q & (state_q == StIdle);
    rem_sh    = rem_q << 1;
    q_bit     = (rem_sh >= {1'b0, div_per_q});
    rem_nx    = q_bit ? (rem_sh - {1'b0, div_per_q}) : rem_sh;
    quo_nx    = (quo_q << 1) | DUTY_LEN'(q_bit);
  end

  // Synchronizer, counter, arming/stuck tracking and the divider FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      hi_lat_q  <= '0;
      div_per_q <= '0;
      div_hi_q  <= '0;
      armed_q   <= 1'b0;
      stuck_q   <= 1'b0;
      overrun_q <= 1'b0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b0;
      dv_q      <= 1'b0;
      it_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
    end else begin
      sync1_q <= pwm_in_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      dv_q    <= 1'b0;

      if (rise) begin
        cnt_q <= CNT_LEN'(1);
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + CNT_LEN'(1);
      end

      if (fall && armed_q) begin
        hi_lat_q <= cnt_q;
      end

      // First rise after reset/stuck only arms; a rise while dividing is dropped.
      if (rise) begin
        stuck_q <= 1'b0;
        if (!armed_q) begin
          armed_q <= 1'b1;
        end else if (busy_q) begin
          overrun_q <= 1'b1;
        end
      end

      if (stuck_evt) begin
        stuck_q <= 1'b1;
        armed_q <= 1'b0;
      end

      if (stuck_req) begin
        if (emit_ok) begin
          dv_q     <= 1'b1;
          duty_q   <= {DUTY_LEN{sync2_q}};
          period_q <= '0;
          high_q   <= '0;
          pend_q   <= 1'b0;
        end else begin
          pend_q <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StIter;
            busy_q    <= 1'b1;
            it_q      <= '0;
            rem_q     <= {1'b0, hi_lat_q};
            quo_q     <= '0;
            div_per_q <= cnt_q;
            div_hi_q  <= hi_lat_q;
          end
        end
        StIter: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          it_q  <= it_q + ItW'(1);
          if (it_q == ItLast) begin
            state_q  <= StDone;
            dv_q     <= 1'b1;
            duty_q   <= quo_nx;
            period_q <= div_per_q;
            high_q   <= div_hi_q;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign duty_o       = duty_q;
  assign duty_valid_o = dv_q;
  assign period_o     = period_q;
  assign high_time_o  = high_q;
  assign busy_o       = busy_q;
  assign stuck_o      = stuck_q;
  assign overrun_o    = overrun_q;
  assign level_o      = sync2_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a 16-bit instance for the main scenarios and
// an 8-bit instance so the stuck-high case fits in a short run.
module tb_pwm_capture;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pwm_i = 1'b0;
  logic pwm_s = 1'b0;

  logic [2:0]  duty, duty_s;
  logic        duty_valid, duty_valid_s;
  logic [15:0] period, high_time;
  logic [7:0]  period_s, high_time_s;
  logic        busy, stuck, overrun, level;
  logic        busy_s, stuck_s, overrun_s, level_s;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  int unsigned ecnt = 0;
  int unsigned n_strobe = 0;
  int unsigned last_edge = 0;
  int unsigned prev_edge = 0;
  int unsigned rise_edge = 0;
  logic [2:0]  s_duty = '0;
  logic [15:0] s_per = '0;
  logic [15:0] s_hi = '0;

  pwm_capture #(.CNT_LEN(16), .DUTY_LEN(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .pwm_in_i     (pwm_i),
    .duty_o       (duty),
    .duty_valid_o (duty_valid),
    .period_o     (period),
    .high_time_o  (high_time),
    .busy_o       (busy),
    .stuck_o      (stuck),
    .overrun_o    (overrun),
    .level_o      (level)
  );

  pwm_capture #(.CNT_LEN(8), .DUTY_LEN(3)) dut_s (
    .clk          (clk),
    .rst          (rst),
    .pwm_in_i     (pwm_s),
    .duty_o       (duty_s),
    .duty_valid_o (duty_valid_s),
    .period_o     (period_s),
    .high_time_o  (high_time_s),
    .busy_o       (busy_s),
    .stuck_o      (stuck_s),
    .overrun_o    (overrun_s),
    .level_o      (level_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  // Record every strobe of the main instance together with the edge it followed.
  always @(negedge clk) begin
    if (duty_valid === 1'b1) begin
      n_strobe  <= n_strobe + 1;
      prev_edge <= last_edge;
      last_edge <= ecnt;
      s_duty    <= duty;
      s_per     <= period;
      s_hi      <= high_time;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; pwm is high for hi samples out of per.
  task automatic pwm_cycle(input int hi, input int per);
    pwm_i = 1'b1;
    rise_edge = ecnt;
    repeat (hi) @(posedge clk);
    #1 pwm_i = 1'b0;
    repeat (per - hi - 1) @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  int unsigned ns;
  logic        found;

  initial begin
    // Reset state.
    do_reset();
    chk("rst_duty_valid", duty_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_period", period, 0);
    chk("rst_stuck", stuck, 0);

    // Generator waveform 3/8: first rise only arms.
    pwm_cycle(3, 8);
    chk("arm_no_strobe", n_strobe, 0);
    repeat (5) pwm_cycle(3, 8);
    chk("t1_strobes", n_strobe, 5);
    chk("t1_duty", s_duty, 3);
    chk("t1_period", s_per, 8);
    chk("t1_high", s_hi, 3);
    chk("t1_latency", last_edge - rise_edge, 6);
    chk("t1_interval", last_edge - prev_edge, 8);

    // Pulse width sweep at period 8, then 5/12.
    for (int w = 1; w <= 7; w++) begin
      repeat (3) pwm_cycle(w, 8);
      chk($sformatf("sweep_duty_w%0d", w), s_duty, w);
    end
    repeat (3) pwm_cycle(5, 12);
    chk("t2_duty_5of12", s_duty, 3);
    chk("t2_period_12", s_per, 12);
    chk("t2_high_5", s_hi, 5);
    chk("t2_overrun", overrun, 0);

    // Minimum period 5 without overrun, then period 4 with drops.
    repeat (6) pwm_cycle(2, 5);
    chk("t4_duty_p5", s_duty, 3);
    chk("t4_period_p5", s_per, 5);
    chk("t4_interval_p5", last_edge - prev_edge, 5);
    chk("t4_no_overrun", overrun, 0);
    repeat (6) pwm_cycle(2, 4);
    chk("t4_overrun", overrun, 1);
    chk("t4_duty_p4", s_duty, 4);
    chk("t4_period_p4", s_per, 4);
    chk("t4_interval_p4", last_edge - prev_edge, 8);

    // Single-cycle pulse and near-full pulse at period 16.
    repeat (3) pwm_cycle(1, 16);
    chk("t6_high_1", s_hi, 1);
    chk("t6_period_16", s_per, 16);
    chk("t6_duty_1of16", s_duty, 0);
    repeat (3) pwm_cycle(15, 16);
    chk("t6_duty_15of16", s_duty, 7);

    // Reset while the divider is busy.
    ns = n_strobe;
    pwm_i = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t5_busy_before_rst", busy, 1);
    rst = 1'b0;
    pwm_i = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_rst_dv", duty_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_duty", duty, 0);
    chk("t5_rst_period", period, 0);
    chk("t5_rst_high", high_time, 0);
    chk("t5_rst_overrun", overrun, 0);
    chk("t5_rst_level", level, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_no_strobe", n_strobe, ns);
    pwm_cycle(3, 8);
    chk("t5_arm_only", n_strobe, ns);
    pwm_cycle(3, 8);
    chk("t5_strobes", n_strobe, ns + 1);
    chk("t5_duty", s_duty, 3);
    chk("t5_period", s_per, 8);

    // Line held low after reset: stuck exactly when cnt reaches 65535.
    do_reset();
    ns = n_strobe;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    chk("t3_not_yet_stuck", stuck, 0);
    chk("t3_no_early_strobe", n_strobe, ns);
    @(posedge clk);
    #1;
    chk("t3_stuck", stuck, 1);
    chk("t3_stuck_dv", duty_valid, 1);
    chk("t3_stuck_duty", duty, 0);
    chk("t3_stuck_period", period, 0);
    chk("t3_stuck_high", high_time, 0);
    @(posedge clk);
    #1;
    chk("t3_dv_one_cycle", duty_valid, 0);
    pwm_cycle(3, 8);
    chk("t3_rise_clears", stuck, 0);
    chk("t3_rise_no_strobe", n_strobe, ns + 1);

    // Line held high after one rise (8-bit instance): duty all ones.
    chk("t3s_stuck_low", stuck_s, 1);
    pwm_s = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t3s_rise_clears", stuck_s, 0);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (duty_valid_s === 1'b1) found = 1'b1;
    end
    chk("t3s_strobe_seen", found, 1);
    chk("t3s_duty", duty_s, 7);
    chk("t3s_period", period_s, 0);
    chk("t3s_high", high_time_s, 0);
    chk("t3s_stuck", stuck_s, 1);
    chk("t3s_level", level_s, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
